mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
Initiator-side DMA block that drives the data memory's single port to copy `length` bytes from `src_addr` to `dst_addr`. Each step, it issues one aligned read followed by one aligned write. Every step uses the largest legal transfer size (4, 2 or 1 byte) allowed by current alignment and remaining length, so the memory's alignment and bounds rules are never violated. It sits beside the CPU datapath and owns the memory port only while busy.

Parameters:
- MEM_SIZE, 1024, bytes in the target memory; must be a power of two; used for bounds checks.
- MAX_XFER, 4, largest transfer size in bytes; fixed at 4 to match the 32-bit data path.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a copy; sampled only in IDLE.
- src_addr  in  32  source byte address, latched on accepted start.
- dst_addr  in  32  destination byte address, latched on accepted start.
- length  in  32  byte count, latched on accepted start.
- busy  out  1  high in READ and WRITE states.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse when a request is rejected.
- mem_address  out  32  memory byte address.
- mem_read_enable  out  1  memory read strobe.
- mem_write_enable  out  1  memory write strobe.
- mem_write_data  out  32  write data, little-endian: byte i in bits [8i+7:8i].
- mem_xfer_size  out  4  transfer size in bytes: 1, 2 or 4.
- mem_read_data  in  32  combinational read data from memory.

Behaviour:
- States: IDLE, READ, WRITE, DONE, ERR.
- Reset state and outputs (also the IDLE outputs):
  - state=IDLE.
  - busy=0, done=0, error=0.
  - mem_read_enable=0, mem_write_enable=0.
  - mem_address=0, mem_write_data=0, mem_xfer_size=4 (never X).
- Internal registers: src, dst, rem (32b), buf (32b).
- Start acceptance: start is accepted only at a posedge in IDLE. On acceptance, latch src/dst/rem from the inputs, then:
  - length==0 -> DONE.
  - Out of bounds -> ERR. Out of bounds means src_addr+length > MEM_SIZE or dst_addr+length > MEM_SIZE, evaluated in 33-bit arithmetic so that wrap-around also counts as out of bounds.
  - Otherwise -> READ.
- start while busy, DONE or ERR: ignored, not queued.
- Chunk size sz is combinational from the registers: the largest of {4,2,1} with src%sz==0, dst%sz==0 and rem>=sz. The registers only change at the end of WRITE, so sz is identical in the READ/WRITE pair.
- READ: drive mem_read_enable=1, mem_address=src, mem_xfer_size=sz. At the posedge, capture mem_read_data into buf, zero-masking bytes >= sz, then -> WRITE.
- WRITE: drive mem_write_enable=1, mem_address=dst, mem_xfer_size=sz, mem_write_data=buf. At the posedge:
  - src+=sz, dst+=sz, rem-=sz.
  - If rem-sz==0 -> DONE, else -> READ.
- Port strobes: never assert read and write in the same cycle. Both enables are 0 in IDLE, DONE and ERR.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- ERR: error=1 for exactly one cycle, then -> IDLE. No memory access occurs on a rejected request.
- Latency: with N chunks, done is high in cycle 2N+1 after the accepting edge. For length==0, done is high in cycle 1.
- Overlapping regions: copy is strictly ascending-address, chunk by chunk. A destination above the source within the span gets re-read data; this is defined behaviour and is not corrected.
- Reset mid-copy: the next posedge with reset=1 forces IDLE and the reset outputs. Memory writes already committed stay committed, and no partial-chunk write occurs after reset.

Test Plan:
- Aligned copy: preload mem[0..7]=0x11..0x88, start src=0, dst=0x100, len=8.
  - Two 4-byte chunks, R/W/R/W, in cycles 1-4 after the accepting edge.
  - done in cycle 5.
  - mem[0x100..0x107]=0x11..0x88.
- Misaligned split: src=1, dst=3, len=6.
  - Chunk sizes in order are 1, 2, 2, 1.
  - Addresses in order: read 1/write 3, read 2/write 4, read 4/write 6, read 6/write 8.
  - Bytes match; done in cycle 9.
- Mixed sizes: src=2, dst=6, len=8.
  - Chunk sizes in order are 2, 4, 2.
  - done in cycle 7.
  - No memory alignment assertion fires.
- Bounds reject: src=0x3FC, dst=0, len=8.
  - error pulses one cycle; done is never asserted.
  - Enables stay 0; memory is unchanged.
  - src=0xFFFFFFFF, len=2 is also rejected.
- Zero length and busy start: len=0 gives done in cycle 1 with no enables. A second start pulsed mid-copy is ignored, and the first copy completes unchanged.
- Reset mid-op: assert reset during the second WRITE of a 3-chunk copy.
  - Next cycle: IDLE, all outputs at reset values, no done.
  - Only the first chunk is written at the destination.
  - A new start afterwards works normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Single-port memory copy engine: moves a byte range one aligned chunk at a time,
// one read then one write per chunk, never issuing an access the memory would reject.
//
// state   | meaning
// S_IDLE  | waiting for start; memory port released
// S_READ  | reading chunk at src_q into buf_q
// S_WRITE | writing buf_q to dst_q, then advancing pointers
// S_DONE  | one-cycle completion pulse
// S_ERR   | one-cycle rejection pulse, no memory access made
module mem_copy_engine #(
   parameter int unsigned MEM_SIZE = 1024,
   parameter int unsigned MAX_XFER = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [31:0] length,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] mem_address,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_xfer_size,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;

   state_t      state_q, state_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] buf_q, buf_d;

   logic [3:0]  sz;
   logic [31:0] sz32;
   logic [31:0] sz_mask;
   logic [32:0] src_end;
   logic [32:0] dst_end;
   logic        oob;

   always_comb begin
      sz = 4'd1;
      if (src_q[1:0] == 2'b00 && dst_q[1:0] == 2'b00 && rem_q >= 32'd4)
         sz = 4'd4;
      else if (!src_q[0] && !dst_q[0] && rem_q >= 32'd2)
         sz = 4'd2;
   end

   assign sz32 = {28'd0, sz};

   always_comb begin
      case (sz)
         4'd4:    sz_mask = 32'hFFFF_FFFF;
         4'd2:    sz_mask = 32'h0000_FFFF;
         default: sz_mask = 32'h0000_00FF;
      endcase
   end

   // 33-bit sums so that address wrap-around is rejected as well
   assign src_end = {1'b0, src_addr} + {1'b0, length};
   assign dst_end = {1'b0, dst_addr} + {1'b0, length};
   assign oob     = (src_end > 33'(MEM_SIZE)) || (dst_end > 33'(MEM_SIZE));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d = src_addr;
               dst_d = dst_addr;
               rem_d = length;
               if (length == 32'd0)
                  state_d = S_DONE;
               else if (oob)
                  state_d = S_ERR;
               else
                  state_d = S_READ;
            end
         end
         S_READ: begin
            buf_d   = mem_read_data & sz_mask;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            src_d   = src_q + sz32;
            dst_d   = dst_q + sz32;
            rem_d   = rem_q - sz32;
            state_d = (rem_q == sz32) ? S_DONE : S_READ;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are forced idle while reset is high so an in-flight write never commits
   always_comb begin
      busy             = 1'b0;
      done             = 1'b0;
      error            = 1'b0;
      mem_address      = '0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_write_data   = '0;
      mem_xfer_size    = 4'(MAX_XFER);
      if (!reset) begin
         case (state_q)
            S_READ: begin
               busy            = 1'b1;
               mem_read_enable = 1'b1;
               mem_address     = src_q;
               mem_xfer_size   = sz;
            end
            S_WRITE: begin
               busy             = 1'b1;
               mem_write_enable = 1'b1;
               mem_address      = dst_q;
               mem_xfer_size    = sz;
               mem_write_data   = buf_q;
            end
            S_DONE:  done  = 1'b1;
            S_ERR:   error = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
